// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared encodings and helpers for the hazard controller
//
// Purpose : FSM state encodings, stall-class (N) encodings and small helper
//           functions shared by the hazard detector and the controller top.
// Contents: state_e    - controller FSM states (RUN, STALL_EXTRA)
//           nclass_e   - number of stall cycles a hazard needs (NONE/ONE/TWO)
//           src_hit    - one source operand matches the EX destination
//           nclass_max - larger of two stall classes
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN         = 2'b00,
    ST_STALL_EXTRA = 2'b01
  } state_e;

  typedef enum logic [1:0] {
    N_NONE = 2'd0,
    N_ONE  = 2'd1,
    N_TWO  = 2'd2
  } nclass_e;

  // $0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic src_hit(
    input logic       use_src,
    input logic [4:0] src,
    input logic [4:0] ex_rd,
    input logic       ex_regw
  );
    return use_src && (src != 5'd0) && ex_regw && (ex_rd == src);
  endfunction

  function automatic nclass_e nclass_max(input nclass_e a, input nclass_e b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// rtl/pipeline_hazard_ctrl_hazard_detect.sv - combinational load-use / branch-operand hazard classifier
//
// Purpose : Compares the ID-stage source registers against the EX-stage
//           destination and reports how many stall cycles are needed.
// Ports   : i_id_rs, i_id_rt         ID source register numbers
//           i_id_use_rs, i_id_use_rt ID instruction really reads rs / rt
//           i_id_is_branch           ID instruction needs operands in ID
//           i_ex_rf_rd               EX destination register
//           i_ex_regw, i_ex_memr     EX writes the RF / EX is a load
//           o_n                      required stall cycles (nclass_e)
module pipeline_hazard_ctrl_hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_use_rs,
  input  logic       i_id_use_rt,
  input  logic       i_id_is_branch,
  input  logic [4:0] i_ex_rf_rd,
  input  logic       i_ex_regw,
  input  logic       i_ex_memr,
  output nclass_e    o_n
);

  logic    w_rs_hit;
  logic    w_rt_hit;
  nclass_e w_rs_n;
  nclass_e w_rt_n;

  assign w_rs_hit = src_hit(i_id_use_rs, i_id_rs, i_ex_rf_rd, i_ex_regw);
  assign w_rt_hit = src_hit(i_id_use_rt, i_id_rt, i_ex_rf_rd, i_ex_regw);

  // A branch compares in ID, so even an ALU result in EX is one cycle late;
  // a load in EX is two cycles late for a branch. Non-branch consumers get
  // ALU results by forwarding and only wait one cycle behind a load.
  function automatic nclass_e classify(input logic hit);
    nclass_e n;
    n = N_NONE;
    if (hit) begin
      if (i_id_is_branch) begin
        n = i_ex_memr ? N_TWO : N_ONE;
      end else if (i_ex_memr) begin
        n = N_ONE;
      end
    end
    return n;
  endfunction

  assign w_rs_n = classify(w_rs_hit);
  assign w_rt_n = classify(w_rt_hit);
  assign o_n    = nclass_max(w_rs_n, w_rt_n);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for the 5-stage MIPS pipeline
//
// Purpose : Freezes or bubbles the pipeline on load-use and branch-operand
//           hazards, squashes the wrong-path fetch after a taken redirect and
//           holds everything while data memory is busy. Counts stall and
//           flush events with saturating counters.
// Ports   : clk, rst                    clock, async active-high reset
//           i_id_*                      ID-stage instruction fields
//           i_ex_*                      EX-stage producer fields
//           i_mem_busy                  data memory not ready, hold all
//           o_pc_write .. o_memwb_write stage register write enables
//           o_ifid_flush, o_idex_flush  bubble insertion on next edge
//           o_stall_cnt, o_flush_cnt    saturating event counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_use_rs,
  input  logic             i_id_use_rt,
  input  logic             i_id_is_branch,
  input  logic             i_id_redirect,
  input  logic [4:0]       i_ex_rf_rd,
  input  logic             i_ex_regw,
  input  logic             i_ex_memr,
  input  logic             i_mem_busy,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_idex_write,
  output logic             o_exmem_write,
  output logic             o_memwb_write,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           r_state;
  state_e           w_state_nxt;
  nclass_e          w_n;
  logic             w_stall;
  logic             w_flush;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
    .i_id_rs        (i_id_rs),
    .i_id_rt        (i_id_rt),
    .i_id_use_rs    (i_id_use_rs),
    .i_id_use_rt    (i_id_use_rt),
    .i_id_is_branch (i_id_is_branch),
    .i_ex_rf_rd     (i_ex_rf_rd),
    .i_ex_regw      (i_ex_regw),
    .i_ex_memr      (i_ex_memr),
    .o_n            (w_n)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and Mealy output decode. Priority is mem_busy, then stall,
  // then flush. A busy cycle leaves the state untouched, so a hazard seen
  // under mem_busy is simply re-evaluated once memory is ready.
  always_comb begin
    w_state_nxt   = r_state;
    w_stall       = 1'b0;
    w_flush       = 1'b0;
    o_pc_write    = 1'b1;
    o_ifid_write  = 1'b1;
    o_idex_write  = 1'b1;
    o_exmem_write = 1'b1;
    o_memwb_write = 1'b1;
    o_ifid_flush  = 1'b0;
    o_idex_flush  = 1'b0;

    if (rst) begin
      o_pc_write    = 1'b0;
      o_ifid_write  = 1'b0;
      o_idex_write  = 1'b0;
      o_exmem_write = 1'b0;
      o_memwb_write = 1'b0;
    end else if (i_mem_busy) begin
      o_pc_write    = 1'b0;
      o_ifid_write  = 1'b0;
      o_idex_write  = 1'b0;
      o_exmem_write = 1'b0;
      o_memwb_write = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_n != N_NONE) begin
            w_stall = 1'b1;
            if (w_n == N_TWO) begin
              w_state_nxt = ST_STALL_EXTRA;
            end
          end else if (i_id_redirect) begin
            // Redirect is only honoured once the branch operands are ready.
            w_flush = 1'b1;
          end
        end
        ST_STALL_EXTRA: begin
          // The bubble now in EX hides the producer, so hazard inputs are
          // not consulted; the second stall cycle is unconditional.
          w_stall     = 1'b1;
          w_state_nxt = ST_RUN;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase

      if (w_stall) begin
        o_pc_write   = 1'b0;
        o_ifid_write = 1'b0;
        o_idex_flush = 1'b1;
      end
      o_ifid_flush = w_flush;
    end
  end

  // Saturating event counters. w_stall and w_flush are already masked by
  // rst and mem_busy in the decode above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rf_rd = '0;
  logic       id_use_rs = 0, id_use_rt = 0, id_is_branch = 0, id_redirect = 0;
  logic       ex_regw = 0, ex_memr = 0, mem_busy = 0;

  logic        pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic        ifid_flush, idex_flush;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_write, s_ifid_write, s_idex_write, s_exmem_write, s_memwb_write;
  logic        s_ifid_flush, s_idex_flush;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt),
    .i_id_is_branch(id_is_branch), .i_id_redirect(id_redirect),
    .i_ex_rf_rd(ex_rf_rd), .i_ex_regw(ex_regw), .i_ex_memr(ex_memr), .i_mem_busy(mem_busy),
    .o_pc_write(pc_write), .o_ifid_write(ifid_write), .o_idex_write(idex_write),
    .o_exmem_write(exmem_write), .o_memwb_write(memwb_write),
    .o_ifid_flush(ifid_flush), .o_idex_flush(idex_flush),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, used to reach saturation quickly.
  pipeline_hazard_ctrl #(.CNT_W(4)) u_dut_small (
    .clk(clk), .rst(rst),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt),
    .i_id_is_branch(id_is_branch), .i_id_redirect(id_redirect),
    .i_ex_rf_rd(ex_rf_rd), .i_ex_regw(ex_regw), .i_ex_memr(ex_memr), .i_mem_busy(mem_busy),
    .o_pc_write(s_pc_write), .o_ifid_write(s_ifid_write), .o_idex_write(s_idex_write),
    .o_exmem_write(s_exmem_write), .o_memwb_write(s_memwb_write),
    .o_ifid_flush(s_ifid_flush), .o_idex_flush(s_idex_flush),
    .o_stall_cnt(s_stall_cnt), .o_flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_left = 0;   // stall cycles still owed after the current one
  int m_sc = 0;
  int m_fc = 0;

  function automatic int stalls_needed();
    bit hit;
    hit = ex_regw && ((id_use_rs && id_rs != 0 && id_rs == ex_rf_rd) ||
                      (id_use_rt && id_rt != 0 && id_rt == ex_rf_rd));
    if (!hit) return 0;
    if (id_is_branch) return ex_memr ? 2 : 1;
    return ex_memr ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    int en, st, fl, n;
    en = 0; st = 0; fl = 0;
    if (rst) begin
      m_left = 0; m_sc = 0; m_fc = 0;
    end else if (mem_busy) begin
      en = 0;
    end else if (m_left > 0) begin
      st = 1; m_left--;
    end else begin
      n = stalls_needed();
      if (n > 0) begin
        st = 1; m_left = n - 1;
      end else begin
        fl = id_redirect ? 1 : 0;
      end
    end
    if (!rst && !mem_busy) en = 1;
    chk("pc_write",    int'(pc_write),    en & ~st);
    chk("ifid_write",  int'(ifid_write),  en & ~st);
    chk("idex_write",  int'(idex_write),  en);
    chk("exmem_write", int'(exmem_write), en);
    chk("memwb_write", int'(memwb_write), en);
    chk("idex_flush",  int'(idex_flush),  st);
    chk("ifid_flush",  int'(ifid_flush),  fl);
    chk("stall_cnt",   int'(stall_cnt),   (m_sc > 65535) ? 65535 : m_sc);
    chk("flush_cnt",   int'(flush_cnt),   (m_fc > 65535) ? 65535 : m_fc);
    chk("s_stall_cnt", int'(s_stall_cnt), (m_sc > 15) ? 15 : m_sc);
    chk("s_pc_write",  int'(s_pc_write),  en & ~st);
    // counters advance at the coming edge
    if (!rst) begin
      m_sc += st;
      m_fc += fl;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_is_branch = 0;
    id_redirect = 0; ex_rf_rd = 0; ex_regw = 0; ex_memr = 0; mem_busy = 0;
  endtask

  task automatic do_reset();
    rst = 1; clear_in();
    tick();
    rst = 0;
  endtask

  task automatic ex_load(input logic [4:0] rd);
    ex_rf_rd = rd; ex_regw = 1; ex_memr = 1;
  endtask

  initial begin
    clear_in();
    tick(); tick();
    chk("rst_pc_write", int'(pc_write), 0);
    chk("rst_memwb_write", int'(memwb_write), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    rst = 0;
    #1 chk("run_pc_write", int'(pc_write), 1);

    // lw $2 in EX, add rs=2 in ID: one stall cycle
    ex_load(2); id_rs = 2; id_use_rs = 1;
    #1 chk("lu_pc_write", int'(pc_write), 0);
    chk("lu_ifid_write", int'(ifid_write), 0);
    chk("lu_idex_flush", int'(idex_flush), 1);
    chk("lu_exmem_write", int'(exmem_write), 1);
    tick();
    ex_regw = 0; ex_memr = 0; ex_rf_rd = 0;
    #1 chk("lu_after_pc_write", int'(pc_write), 1);
    chk("lu_stall_cnt", int'(stall_cnt), 1);

    // lw $3 in EX, beq rt=3: two stall cycles
    do_reset();
    ex_load(3); id_rt = 3; id_use_rt = 1; id_is_branch = 1;
    #1 chk("lb_stall1", int'(pc_write), 0);
    tick();
    #1 chk("lb_stall2", int'(pc_write), 0);
    tick();
    ex_regw = 0; ex_memr = 0;
    #1 chk("lb_done", int'(pc_write), 1);
    chk("lb_stall_cnt", int'(stall_cnt), 2);

    // add $4 in EX, bne rs=4 with redirect: stall only, then flush
    do_reset();
    ex_rf_rd = 4; ex_regw = 1; id_rs = 4; id_use_rs = 1; id_is_branch = 1; id_redirect = 1;
    #1 chk("ab_stall", int'(pc_write), 0);
    chk("ab_no_flush", int'(ifid_flush), 0);
    tick();
    ex_regw = 0;
    #1 chk("ab_flush", int'(ifid_flush), 1);
    chk("ab_flush_pc", int'(pc_write), 1);
    tick();
    id_redirect = 0;
    #1 chk("ab_flush_cnt", int'(flush_cnt), 1);
    chk("ab_stall_cnt", int'(stall_cnt), 1);
    chk("ab_flush_off", int'(ifid_flush), 0);

    // write to $0 never stalls
    do_reset();
    ex_load(0); id_rs = 0; id_use_rs = 1; id_rt = 0; id_use_rt = 1; id_is_branch = 1;
    #1 chk("r0_pc_write", int'(pc_write), 1);
    chk("r0_idex_flush", int'(idex_flush), 0);
    tick();
    #1 chk("r0_stall_cnt", int'(stall_cnt), 0);

    // mem_busy for 3 cycles at the start of a 2-stall sequence
    do_reset();
    ex_load(3); id_rt = 3; id_use_rt = 1; id_is_branch = 1; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mb_pc_write", int'(pc_write), 0);
      chk("mb_memwb_write", int'(memwb_write), 0);
      chk("mb_idex_flush", int'(idex_flush), 0);
      tick();
    end
    mem_busy = 0;
    #1 chk("mb_stall1", int'(idex_flush), 1);
    tick();
    #1 chk("mb_stall2", int'(idex_flush), 1);
    tick();
    ex_regw = 0; ex_memr = 0;
    #1 chk("mb_done", int'(pc_write), 1);
    chk("mb_stall_cnt", int'(stall_cnt), 2);

    // saturation on the narrow instance, then reset inside STALL_EXTRA
    do_reset();
    for (int i = 0; i < 20; i++) begin
      ex_load(5); id_rs = 5; id_use_rs = 1;
      tick();
      ex_regw = 0; ex_memr = 0;
      tick();
    end
    #1 chk("sat_small", int'(s_stall_cnt), 15);
    chk("sat_main", int'(stall_cnt), 20);
    ex_load(6); id_rt = 6; id_use_rt = 1; id_is_branch = 1;
    tick();
    #1 chk("sx_stall", int'(pc_write), 0);
    rst = 1;
    #1 chk("sx_rst_pc", int'(pc_write), 0);
    chk("sx_rst_exmem", int'(exmem_write), 0);
    chk("sx_rst_idex_flush", int'(idex_flush), 0);
    chk("sx_rst_cnt", int'(stall_cnt), 0);
    tick();
    rst = 0; clear_in();
    #1 chk("sx_run", int'(pc_write), 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=1 expected=0");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Stall/flush controller for the 5-stage MIPS pipeline. Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It detects load-use and branch-operand hazards against the ID-stage instruction and drives the per-stage write enables and reset pulses that freeze or bubble the pipeline. It also squashes the wrong-path fetch after a taken branch or jump, and keeps saturating stall and flush event counters.

## Interface
- CNT_W, 16, width of the stall and flush event counters
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs, id_rt  in  5 each  source register numbers of the ID instruction
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt
- id_is_branch  in  1  ID instruction is beq/bne/jr; it needs its operands in ID
- id_redirect  in  1  ID resolved a taken branch or jump (PcSel or jump)
- ex_rf_rd  in  5  destination register of the EX instruction
- ex_regw, ex_memr  in  1 each  EX instruction writes the RF / is a load
- mem_busy  in  1  data memory not ready; the whole pipeline must hold
- pc_write, ifid_write, idex_write, exmem_write, memwb_write  out  1  stage register write enables
- ifid_flush, idex_flush  out  1  synchronous clear of IF/ID / ID/EX on the next edge, inserting a bubble
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Hazard match: for a source r in {rs if id_use_rs, rt if id_use_rt}, hazard if r != 0, ex_regw=1 and ex_rf_rd == r.
- Required stall cycles N for a match:
  - non-branch with an EX load: N=1.
  - branch with an EX ALU producer (ex_memr=0): N=1.
  - branch with an EX load: N=2.
  - Otherwise N=0. MEM-stage results are covered by forwarding.
- FSM states: RUN, STALL_EXTRA (encodings 2'b00, 2'b01).
- RUN:
  - If N≥1: stall this cycle (pc_write=0, ifid_write=0, idex_flush=1, other enables 1).
  - If N=2: next state is STALL_EXTRA. Otherwise stay in RUN.
- STALL_EXTRA:
  - Unconditionally stall one more cycle with the same outputs, then return to RUN.
  - Hazard inputs are ignored in this state, because the bubble in EX hides the producer.
- Flush: in RUN with N=0, id_redirect=1 raises ifid_flush=1 for that cycle, and all enables stay 1. id_redirect is ignored while stalling; the branch resolves after the stall.
- Priority: mem_busy > stall > flush.
- mem_busy=1:
  - All five write enables are 0, and both flushes are 0.
  - FSM state and counters hold.
  - A stall pending in that cycle is deferred, not lost.
- Counters:
  - stall_cnt increments on each stall cycle that is not held by mem_busy.
  - flush_cnt increments on each ifid_flush cycle.
  - Both saturate at all-ones.

## Timing
- Outputs are combinational (Mealy) from state and current inputs. They are valid in the same cycle as their inputs and take effect at the next clk edge.
- Reset: while rst=1, state=RUN, counters=0, all write enables=0, both flushes=0.
- After rst falls, outputs follow the rules above from the first cycle.
- rst mid-stall, including in STALL_EXTRA, abandons the stall immediately.
- Stall latency: the 1-stall case costs exactly 1 cycle, and the 2-stall case exactly 2, not counting mem_busy cycles.
- A simultaneous hazard match on rs and rt uses the larger N.
- id_redirect together with N≥1: stall only, no flush that cycle.

## Structure
- FSM state encodings and the N-class constants (NONE, ONE, TWO) go in ctrl_encode_def.v alongside the existing control encodings.
- One natural sub-module: hazard_detect (combinational). It takes the ID/EX fields above and outputs N[1:0].
- pipeline_hazard_ctrl holds the FSM, output decode and counters.

## Test plan
- lw $2 in EX (ex_memr=1, ex_regw=1, ex_rf_rd=2), add using rs=2 in ID:
  - exactly 1 cycle with pc_write=0, ifid_write=0, idex_flush=1, then normal;
  - stall_cnt goes 0→1.
- lw $3 in EX, beq with rt=3 in ID (id_is_branch=1):
  - 2 consecutive stall cycles;
  - FSM visits STALL_EXTRA once;
  - stall_cnt=2.
- add $4 in EX, bne rs=4 in ID: 1 stall cycle. Then id_redirect=1 in RUN gives ifid_flush=1 for 1 cycle, and flush_cnt=1.
- Write to $0 (ex_rf_rd=0, ex_regw=1, load) with ID rs=0: no stall.
- mem_busy=1 for 3 cycles during the first cycle of a 2-stall sequence:
  - all enables are 0 for 3 cycles;
  - then the 2 stall cycles complete;
  - stall_cnt=2.
- Force stall_cnt to 16'hFFFF via repeated stalls, then one more stall: the counter stays at 16'hFFFF. Assert rst in STALL_EXTRA: state returns to RUN, all outputs go to 0, counters clear immediately.
